addsub_seg_ctrl: RTL

ADDSUB_SEG_CTRL -- requirements
Module: addsub_seg_ctrl

---
 rtl/addsub_seg_pkg.sv | 21 ++
 rtl/addsub_seg_ctrl_hex7seg.sv | 32 +++
 rtl/addsub_seg_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/addsub_seg_pkg.sv
// Shared definitions for the add/subtract seven-segment controller.
//   SEG_BLANK     : all segments and decimal point off (active-low)
//   view_e        : display page selection (operands or result/flags)
//   dig_idx_t     : 2-bit index of the digit currently being scanned
//   dig_enable_n  : one-hot active-low digit enable for a digit index
package addsub_seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic {
        VIEW_OPERANDS = 1'b0,
        VIEW_RESULT   = 1'b1
    } view_e;

    typedef logic [1:0] dig_idx_t;

    function automatic logic [3:0] dig_enable_n(input dig_idx_t idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/addsub_seg_ctrl_hex7seg.sv
// Hex nibble to seven-segment decoder.
//   i_nib : 4-bit value 0..F
//   o_seg : segments {g,f,e,d,c,b,a}, active-low
module hex7seg (
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nib)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/addsub_seg_ctrl.sv
// Push-button driven add/subtract unit with a 4-digit multiplexed
// seven-segment display.
//   clk  : system clock          nrst : async active-low reset
//   a, b : operand switches      op   : 0 = add, 1 = subtract
//   load : async push-button, rising edge captures a/b/op
//   view : 0 = show operands, 1 = show flags + result
//   done : one-cycle pulse when a new result is registered
//   seg  : {dp,g,f,e,d,c,b,a} active-low, dig : one-hot active-low
module addsub_seg_ctrl
    import addsub_seg_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int SCAN_MAX = 99999
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic             load,
    input  logic             view,
    output logic             done,
    output logic [7:0]       seg,
    output logic [3:0]       dig
);

    localparam int CW = (SCAN_MAX > 0) ? $clog2(SCAN_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_MAX);

    logic             r_sync1, r_sync2, r_hist;
    logic [WIDTH-1:0] r_opA, r_opB, r_result;
    logic             r_opS, r_calc, r_c, r_v;
    logic [CW-1:0]    r_cnt;
    dig_idx_t         r_idx;

    logic             w_strobe;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;
    logic [7:0]       w_a8, w_b8, w_res8, w_seg_next;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg7;
    logic             w_dp, w_blank;
    view_e            w_view;

    // Edge detect on the synchronized button level.
    assign w_strobe = r_sync2 & ~r_hist;

    assign w_sum  = {1'b0, r_opA} + {1'b0, r_opB};
    assign w_diff = {1'b0, r_opA} - {1'b0, r_opB};

    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (r_opA[WIDTH-1] == r_opB[WIDTH-1]) && (w_sum[WIDTH-1] != r_opA[WIDTH-1]);
        if (r_opS) begin
            // Top bit of the widened difference is the borrow (opA < opB).
            w_res = w_diff[WIDTH-1:0];
            w_c   = w_diff[WIDTH];
            w_v   = (r_opA[WIDTH-1] != r_opB[WIDTH-1]) && (w_diff[WIDTH-1] != r_opA[WIDTH-1]);
        end
    end

    assign w_a8   = 8'(a);
    assign w_b8   = 8'(b);
    assign w_res8 = 8'(r_result);
    assign w_view = view_e'(view);

    always_comb begin
        w_nib   = '0;
        w_dp    = 1'b1;
        w_blank = 1'b0;
        case (r_idx)
            2'd3: w_nib = (w_view == VIEW_RESULT) ? {1'b0, r_opS, r_v, r_c} : w_a8[7:4];
            2'd2: begin
                if (w_view == VIEW_RESULT) begin
                    w_blank = 1'b1;
                    w_dp    = 1'b0;
                end else begin
                    w_nib = w_a8[3:0];
                end
            end
            2'd1: w_nib = (w_view == VIEW_RESULT) ? w_res8[7:4] : w_b8[7:4];
            default: w_nib = (w_view == VIEW_RESULT) ? w_res8[3:0] : w_b8[3:0];
        endcase
    end

    hex7seg u_hex7seg (
        .i_nib (w_nib),
        .o_seg (w_seg7)
    );

    assign w_seg_next = w_blank ? {w_dp, SEG_BLANK[6:0]} : {w_dp, w_seg7};

    // Button synchronizer, operand capture and arithmetic result.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_hist   <= 1'b0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_opS    <= 1'b0;
            r_calc   <= 1'b0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_sync1 <= load;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_calc  <= w_strobe;
            if (w_strobe) begin
                r_opA <= a;
                r_opB <= b;
                r_opS <= op;
            end
            if (r_calc) begin
                r_result <= w_res;
                r_c      <= w_c;
                r_v      <= w_v;
            end
            done <= r_calc;
        end
    end

    // Scan divider, digit index and registered display outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
            r_idx <= '0;
            seg   <= SEG_BLANK;
            dig   <= 4'hF;
        end else begin
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            seg <= w_seg_next;
            dig <= dig_enable_n(r_idx);
        end
    end

endmodule
